// File: rtl/ina220_reader.sv
// ina220_reader
// Reads one 16-bit INA220 register through a CoreI2C master-mode instance.
// The block drives CoreI2C over APB3 and runs the I2C transaction itself:
// START, SLA+W, pointer write, repeated START, SLA+R, MSB read with ACK,
// LSB read with NACK, STOP. After every CTRL write it polls STAT until the
// bus has settled, then compares the result with the status expected for
// that step.
//
// Ports
//   PCLK, PRESETN      clock (rising edge), asynchronous active-low reset
//   START, REG_PTR     one-cycle read request and INA220 register pointer
//   PADDR .. PWRITE    APB3 master outputs to CoreI2C
//   PRDATA, PREADY     APB3 read data and ready from CoreI2C
//   DATA_OUT           last good register value {MSB, LSB}
//   DATA_VALID         one-cycle pulse when DATA_OUT updates
//   BUSY               high from START acceptance until the sequence ends
//   ERR, ERR_CODE      sticky error flag and the offending status byte
//   DBG_STATE          current sequencer state, for debug and checkers
//
// APB handshake: an access starts with a setup cycle (PSEL=1, PENABLE=0),
// followed by access cycles (PSEL=1, PENABLE=1). The access ends on the
// first rising edge that sees PREADY=1; address, data and direction stay
// constant until then. PSEL and PENABLE then return to 0 for at least one
// cycle before the next setup cycle.
module ina220_reader #(
    parameter logic [6:0]  DEV_ADDR   = 7'h40,
    parameter logic [15:0] POLL_LIMIT = 16'd50000,
    parameter logic [2:0]  CR_BITS    = 3'b000
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        START,
    input  logic [7:0]  REG_PTR,
    output logic [8:0]  PADDR,
    output logic [7:0]  PWDATA,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    input  logic [7:0]  PRDATA,
    input  logic        PREADY,
    output logic [15:0] DATA_OUT,
    output logic        DATA_VALID,
    output logic        BUSY,
    output logic        ERR,
    output logic [7:0]  ERR_CODE,
    output logic [2:0]  DBG_STATE
);

    localparam logic [8:0] ADDR_CTRL = 9'h000;
    localparam logic [8:0] ADDR_STAT = 9'h004;
    localparam logic [8:0] ADDR_DATA = 9'h008;

    // CR2 sits in CTRL bit 7; CR1/CR0 sit in bits 1 and 0.
    localparam logic [7:0] CR_MASK   = {CR_BITS[2], 5'b00000, CR_BITS[1:0]};
    localparam logic [7:0] CTRL_STOP = 8'h50 | CR_MASK;
    localparam logic [7:0] STAT_IDLE = 8'hF8;

    // The state names the APB operation in progress; the phase tracks where
    // that operation is within its APB access.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DATA_WR = 3'd1,
        ST_CTRL_WR = 3'd2,
        ST_POLL    = 3'd3,
        ST_DATA_RD = 3'd4,
        ST_ABORT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PH_LAUNCH = 2'd0,
        PH_SETUP  = 2'd1,
        PH_ACCESS = 2'd2
    } phase_t;

    state_t      state;
    phase_t      phase;
    logic [3:0]  step;
    logic [7:0]  reg_ptr_q;
    logic [7:0]  msb_q;
    logic [7:0]  lsb_q;
    logic [15:0] poll_cnt;
    logic        just_done;

    logic [8:0]  op_addr;
    logic [7:0]  op_wdata;
    logic        op_write;
    logic [7:0]  ctrl_base;
    logic [7:0]  exp_status;
    logic [3:0]  step_nxt;
    logic [15:0] cnt_nxt;
    state_t      next_op;

    assign DBG_STATE = state;

    always_comb begin
        step_nxt = step + 4'd1;
        cnt_nxt  = poll_cnt + 16'd1;

        case (step)
            4'd1, 4'd4: ctrl_base = 8'h60;   // ENS1 | STA
            4'd6:       ctrl_base = 8'h44;   // ENS1 | AA, ACK the MSB
            4'd8:       ctrl_base = 8'h50;   // ENS1 | STO
            default:    ctrl_base = 8'h40;   // ENS1 only
        endcase

        case (step)
            4'd1:    exp_status = 8'h08;
            4'd2:    exp_status = 8'h18;
            4'd3:    exp_status = 8'h28;
            4'd4:    exp_status = 8'h10;
            4'd5:    exp_status = 8'h40;
            4'd6:    exp_status = 8'h50;
            4'd7:    exp_status = 8'h58;
            default: exp_status = 8'h00;
        endcase

        // Steps 2, 3 and 5 load DATA before their CTRL write.
        if (step_nxt == 4'd2 || step_nxt == 4'd3 || step_nxt == 4'd5)
            next_op = ST_DATA_WR;
        else
            next_op = ST_CTRL_WR;

        op_addr  = ADDR_CTRL;
        op_wdata = 8'h00;
        op_write = 1'b0;
        case (state)
            ST_DATA_WR: begin
                op_addr  = ADDR_DATA;
                op_write = 1'b1;
                case (step)
                    4'd2:    op_wdata = {DEV_ADDR, 1'b0};
                    4'd3:    op_wdata = reg_ptr_q;
                    default: op_wdata = {DEV_ADDR, 1'b1};
                endcase
            end
            ST_CTRL_WR: begin
                op_addr  = ADDR_CTRL;
                op_write = 1'b1;
                op_wdata = ctrl_base | CR_MASK;
            end
            ST_POLL:    op_addr = ADDR_STAT;
            ST_DATA_RD: op_addr = ADDR_DATA;
            ST_ABORT: begin
                op_addr  = ADDR_CTRL;
                op_write = 1'b1;
                op_wdata = CTRL_STOP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state      <= ST_IDLE;
            phase      <= PH_LAUNCH;
            step       <= 4'd0;
            reg_ptr_q  <= 8'h00;
            msb_q      <= 8'h00;
            lsb_q      <= 8'h00;
            poll_cnt   <= 16'd0;
            just_done  <= 1'b0;
            PADDR      <= 9'h000;
            PWDATA     <= 8'h00;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            DATA_OUT   <= 16'h0000;
            DATA_VALID <= 1'b0;
            BUSY       <= 1'b0;
            ERR        <= 1'b0;
            ERR_CODE   <= 8'h00;
        end else begin
            DATA_VALID <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // just_done blocks a START that coincides with BUSY falling.
                    just_done <= 1'b0;
                    phase     <= PH_LAUNCH;
                    if (START && !just_done) begin
                        reg_ptr_q <= REG_PTR;
                        BUSY      <= 1'b1;
                        ERR       <= 1'b0;
                        ERR_CODE  <= 8'h00;
                        step      <= 4'd1;
                        state     <= ST_CTRL_WR;
                    end
                end
                default: begin
                    case (phase)
                        PH_LAUNCH: begin
                            // PSEL is low in this cycle, which provides the
                            // idle gap between consecutive accesses.
                            PSEL    <= 1'b1;
                            PENABLE <= 1'b0;
                            PADDR   <= op_addr;
                            PWDATA  <= op_wdata;
                            PWRITE  <= op_write;
                            phase   <= PH_SETUP;
                        end
                        PH_SETUP: begin
                            PENABLE <= 1'b1;
                            phase   <= PH_ACCESS;
                        end
                        default: begin
                            if (PREADY) begin
                                PSEL    <= 1'b0;
                                PENABLE <= 1'b0;
                                PWRITE  <= 1'b0;
                                PWDATA  <= 8'h00;
                                phase   <= PH_LAUNCH;
                                case (state)
                                    ST_DATA_WR: state <= ST_CTRL_WR;
                                    ST_CTRL_WR: begin
                                        if (step == 4'd8) begin
                                            state      <= ST_IDLE;
                                            BUSY       <= 1'b0;
                                            DATA_OUT   <= {msb_q, lsb_q};
                                            DATA_VALID <= 1'b1;
                                            just_done  <= 1'b1;
                                        end else begin
                                            state    <= ST_POLL;
                                            poll_cnt <= 16'd0;
                                        end
                                    end
                                    ST_POLL: begin
                                        poll_cnt <= cnt_nxt;
                                        if (PRDATA == STAT_IDLE) begin
                                            // Still busy on the bus; poll again
                                            // unless the read budget is spent.
                                            if (cnt_nxt >= POLL_LIMIT) begin
                                                ERR      <= 1'b1;
                                                ERR_CODE <= 8'hFF;
                                                state    <= ST_ABORT;
                                            end
                                        end else if (PRDATA == exp_status) begin
                                            if (step == 4'd6 || step == 4'd7) begin
                                                state <= ST_DATA_RD;
                                            end else begin
                                                step  <= step_nxt;
                                                state <= next_op;
                                            end
                                        end else begin
                                            ERR      <= 1'b1;
                                            ERR_CODE <= PRDATA;
                                            state    <= ST_ABORT;
                                        end
                                    end
                                    ST_DATA_RD: begin
                                        if (step == 4'd6)
                                            msb_q <= PRDATA;
                                        else
                                            lsb_q <= PRDATA;
                                        step  <= step_nxt;
                                        state <= next_op;
                                    end
                                    ST_ABORT: begin
                                        state     <= ST_IDLE;
                                        BUSY      <= 1'b0;
                                        just_done <= 1'b1;
                                    end
                                    default: state <= ST_IDLE;
                                endcase
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ina220_reader.sv
// tb_ina220_reader
// Bench for ina220_reader. A behavioural CoreI2C model answers the APB
// accesses: each non-STOP CTRL write takes the next status from a script,
// STAT reads return 0xF8 for a configurable number of polls before that
// status, and DATA reads return scripted bytes. Every APB write is logged
// and compared with the write list expected from the I2C read sequence.
module tb_ina220_reader;

    logic        PCLK;
    logic        PRESETN;
    logic        START;
    logic [7:0]  REG_PTR;
    logic [8:0]  PADDR;
    logic [7:0]  PWDATA;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PRDATA;
    logic        PREADY;
    logic [15:0] DATA_OUT;
    logic        DATA_VALID;
    logic        BUSY;
    logic        ERR;
    logic [7:0]  ERR_CODE;
    logic [2:0]  DBG_STATE;

    ina220_reader #(
        .DEV_ADDR   (7'h40),
        .POLL_LIMIT (16'd8),
        .CR_BITS    (3'b000)
    ) dut (
        .PCLK       (PCLK),
        .PRESETN    (PRESETN),
        .START      (START),
        .REG_PTR    (REG_PTR),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .DATA_OUT   (DATA_OUT),
        .DATA_VALID (DATA_VALID),
        .BUSY       (BUSY),
        .ERR        (ERR),
        .ERR_CODE   (ERR_CODE),
        .DBG_STATE  (DBG_STATE)
    );

    // ---------------- clock / reset ----------------
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // ---------------- shared bench state ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    logic [16:0] wr_log[$];      // {PADDR, PWDATA} of every APB write
    logic [16:0] exp_q[$];       // expected write list for the current case
    logic [7:0]  stat_q[$];      // status script, one entry per CTRL write
    logic [7:0]  data_q[$];      // bytes returned by DATA reads
    int          m_waits = 0;    // PREADY-low cycles per access
    int          m_delay = 0;    // 0xF8 polls before each real status
    int          stat_reads = 0;
    int          proto_err  = 0;
    int          s6_cnt     = 0;
    int          dv_cnt     = 0;
    int          dv_bad     = 0;
    int          lb, db, pb, sb;

    typedef struct {
        logic [7:0]  ptr;
        int          waits;
        int          delay;
        bit          stuck;
        int          fail_step;
        logic [7:0]  fail_st;
        logic [7:0]  msb;
        logic [7:0]  lsb;
        logic [15:0] exp_out;
        logic        exp_err;
        logic [7:0]  exp_code;
        int          exp_reads;
    } vec_t;

    function automatic logic [7:0] nom_status(input int s);
        case (s)
            1: return 8'h08;
            2: return 8'h18;
            3: return 8'h28;
            4: return 8'h10;
            5: return 8'h40;
            6: return 8'h50;
            default: return 8'h58;
        endcase
    endfunction

    function automatic logic [7:0] ctrl_of(input int s);
        case (s)
            1, 4: return 8'h60;
            6:    return 8'h44;
            8:    return 8'h50;
            default: return 8'h40;
        endcase
    endfunction

    // ---------------- CoreI2C APB model + protocol monitor ----------------
    initial begin : responder
        int         ws_cnt;
        int         f8_left;
        bit         stuck;
        logic [7:0] cur_stat;
        int         prev_kind;   // 0 idle, 1 setup, 2 access waiting, 3 access done
        logic [8:0] prev_addr;
        ws_cnt = 0; f8_left = 0; stuck = 1'b1; cur_stat = 8'h00;
        prev_kind = 0; prev_addr = 9'h000;
        PREADY = 1'b0;
        PRDATA = 8'h00;
        forever begin
            @(negedge PCLK);
            if (!PRESETN) begin
                PREADY = 1'b0;
                ws_cnt = 0;
                prev_kind = 0;
            end else begin
                if ((prev_kind == 1 || prev_kind == 2) &&
                    (!(PSEL && PENABLE) || PADDR != prev_addr))
                    proto_err++;
                if (prev_kind == 3 && PSEL)
                    proto_err++;
                if (PENABLE && !PSEL)
                    proto_err++;
                if (PSEL && PWRITE && PADDR == 9'h004)
                    proto_err++;
                prev_addr = PADDR;
                if (PSEL && PENABLE) begin
                    if (ws_cnt < m_waits) begin
                        PREADY = 1'b0;
                        ws_cnt++;
                        prev_kind = 2;
                    end else begin
                        PREADY = 1'b1;
                        ws_cnt = 0;
                        prev_kind = 3;
                        PRDATA = 8'h00;
                        if (PWRITE) begin
                            wr_log.push_back({PADDR, PWDATA});
                            if (PADDR == 9'h000) begin
                                if (PWDATA == 8'h44) s6_cnt++;
                                if ((PWDATA & 8'h10) == 8'h00) begin
                                    if (stat_q.size() > 0) begin
                                        cur_stat = stat_q.pop_front();
                                        stuck = 1'b0;
                                    end else begin
                                        stuck = 1'b1;
                                    end
                                    f8_left = m_delay;
                                end
                            end
                        end else begin
                            if (PWDATA != 8'h00) proto_err++;
                            if (PADDR == 9'h004) begin
                                stat_reads++;
                                if (stuck) begin
                                    PRDATA = 8'hF8;
                                end else if (f8_left > 0) begin
                                    PRDATA = 8'hF8;
                                    f8_left--;
                                end else begin
                                    PRDATA = cur_stat;
                                end
                            end else if (PADDR == 9'h008) begin
                                PRDATA = (data_q.size() > 0) ? data_q.pop_front() : 8'hEE;
                            end
                        end
                    end
                end else begin
                    PREADY = 1'b0;
                    ws_cnt = 0;
                    prev_kind = (PSEL && !PENABLE) ? 1 : 0;
                end
            end
        end
    end

    // DATA_VALID must pulse in the very cycle BUSY falls.
    initial begin : dv_mon
        logic prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge PCLK);
            if (DATA_VALID) begin
                dv_cnt++;
                if (BUSY || !prev_busy) dv_bad++;
            end
            prev_busy = BUSY;
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic build_exp(input logic [7:0] ptr, input int fail_step);
        exp_q.delete();
        for (int s = 1; s <= 8; s++) begin
            if (s == 2) exp_q.push_back({9'h008, 8'h80});
            if (s == 3) exp_q.push_back({9'h008, ptr});
            if (s == 5) exp_q.push_back({9'h008, 8'h81});
            exp_q.push_back({9'h000, ctrl_of(s)});
            if (s == fail_step) begin
                exp_q.push_back({9'h000, 8'h50});
                break;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic prep(input vec_t v);
        m_waits = v.waits;
        m_delay = v.delay;
        stat_q.delete();
        data_q.delete();
        if (!v.stuck) begin
            for (int i = 1; i <= 7; i++) begin
                if (v.fail_step == i) begin
                    stat_q.push_back(v.fail_st);
                    break;
                end
                stat_q.push_back(nom_status(i));
            end
        end
        data_q.push_back(v.msb);
        data_q.push_back(v.lsb);
        lb = wr_log.size();
        db = dv_cnt;
        pb = proto_err;
        sb = stat_reads;
        build_exp(v.ptr, v.fail_step);
    endtask

    task automatic start_pulse(input logic [7:0] ptr);
        @(negedge PCLK);
        REG_PTR = ptr;
        START   = 1'b1;
        @(negedge PCLK);
        START   = 1'b0;
    endtask

    // Waits for BUSY to fall (bounded), optionally raising START in that
    // same cycle, then checks results and the logged write sequence.
    task automatic finish(input vec_t v, input bit poke, input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge PCLK);
            if (!BUSY) done = 1'b1;
        end
        check($sformatf("%s_done", tag), {31'd0, done}, 32'd1);
        if (poke) START = 1'b1;
        check($sformatf("%s_dv_at_fall", tag), {31'd0, DATA_VALID}, {31'd0, !v.exp_err});
        check($sformatf("%s_data_out", tag), {16'd0, DATA_OUT}, {16'd0, v.exp_out});
        check($sformatf("%s_err", tag), {31'd0, ERR}, {31'd0, v.exp_err});
        check($sformatf("%s_err_code", tag), {24'd0, ERR_CODE}, {24'd0, v.exp_code});
        @(negedge PCLK);
        check($sformatf("%s_dv_count", tag), dv_cnt - db, v.exp_err ? 0 : 1);
        check($sformatf("%s_n_writes", tag), wr_log.size() - lb, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (lb + i < wr_log.size())
                check($sformatf("%s_write%0d", tag, i), {15'd0, wr_log[lb + i]}, {15'd0, exp_q[i]});
        end
        check($sformatf("%s_apb_protocol", tag), proto_err - pb, 0);
        if (v.exp_reads >= 0)
            check($sformatf("%s_stat_reads", tag), stat_reads - sb, v.exp_reads);
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[7];
    vec_t vn, va, vb;

    initial begin : main
        int rb;
        bit seen;
        PRESETN = 1'b0;
        START   = 1'b0;
        REG_PTR = 8'h00;
        repeat (3) @(negedge PCLK);
        check("rst_psel",     {31'd0, PSEL},       32'd0);
        check("rst_penable",  {31'd0, PENABLE},    32'd0);
        check("rst_pwrite",   {31'd0, PWRITE},     32'd0);
        check("rst_paddr",    {23'd0, PADDR},      32'd0);
        check("rst_pwdata",   {24'd0, PWDATA},     32'd0);
        check("rst_data_out", {16'd0, DATA_OUT},   32'd0);
        check("rst_dv",       {31'd0, DATA_VALID}, 32'd0);
        check("rst_busy",     {31'd0, BUSY},       32'd0);
        check("rst_err",      {31'd0, ERR},        32'd0);
        check("rst_err_code", {24'd0, ERR_CODE},   32'd0);
        check("rst_state",    {29'd0, DBG_STATE},  32'd0);
        PRESETN = 1'b1;
        repeat (2) @(negedge PCLK);

        //          ptr    wt dl stuck fs fail_st msb    lsb    out       err   code   reads
        vecs[0] = '{8'h02, 0, 0, 1'b0, 0, 8'h00, 8'h1F, 8'h40, 16'h1F40, 1'b0, 8'h00, 7};
        vecs[1] = '{8'h02, 3, 1, 1'b0, 0, 8'h00, 8'h1F, 8'h40, 16'h1F40, 1'b0, 8'h00, 14};
        vecs[2] = '{8'h05, 1, 2, 1'b0, 0, 8'h00, 8'hA5, 8'h3C, 16'hA53C, 1'b0, 8'h00, 21};
        vecs[3] = '{8'h02, 0, 1, 1'b0, 2, 8'h20, 8'h11, 8'h22, 16'hA53C, 1'b1, 8'h20, 4};
        vecs[4] = '{8'h00, 2, 0, 1'b0, 5, 8'h48, 8'h11, 8'h22, 16'hA53C, 1'b1, 8'h48, 5};
        vecs[5] = '{8'h01, 0, 0, 1'b1, 1, 8'h00, 8'h11, 8'h22, 16'hA53C, 1'b1, 8'hFF, 8};
        vecs[6] = '{8'h04, 0, 3, 1'b0, 0, 8'h00, 8'h00, 8'h01, 16'h0001, 1'b0, 8'h00, 28};

        for (int i = 0; i < 7; i++) begin
            prep(vecs[i]);
            start_pulse(vecs[i].ptr);
            check($sformatf("v%0d_busy_up", i), {31'd0, BUSY}, 32'd1);
            finish(vecs[i], 1'b0, $sformatf("v%0d", i));
        end

        // START while busy is ignored and a late REG_PTR change has no effect.
        vn = '{8'h02, 0, 0, 1'b0, 0, 8'h00, 8'h1F, 8'h40, 16'h1F40, 1'b0, 8'h00, 7};
        prep(vn);
        start_pulse(8'h02);
        repeat (10) @(negedge PCLK);
        REG_PTR = 8'h77;
        START   = 1'b1;
        @(negedge PCLK);
        START   = 1'b0;
        finish(vn, 1'b0, "h2");
        rb = wr_log.size();
        repeat (8) @(negedge PCLK);
        check("h2_stays_idle", {31'd0, BUSY}, 32'd0);
        check("h2_no_extra_writes", wr_log.size() - rb, 0);

        // START in the cycle BUSY falls is ignored, accepted one cycle later.
        va = '{8'h03, 0, 1, 1'b0, 0, 8'h00, 8'h12, 8'h34, 16'h1234, 1'b0, 8'h00, 14};
        vb = '{8'h06, 1, 0, 1'b0, 0, 8'h00, 8'h56, 8'h78, 16'h5678, 1'b0, 8'h00, 7};
        prep(va);
        start_pulse(8'h03);
        REG_PTR = 8'h06;
        finish(va, 1'b1, "h3a");
        check("h3_fall_start_ignored", {31'd0, BUSY}, 32'd0);
        prep(vb);
        @(negedge PCLK);
        check("h3_next_start_accepted", {31'd0, BUSY}, 32'd1);
        START = 1'b0;
        finish(vb, 1'b0, "h3b");

        // Reset during S6, then a clean full sequence.
        prep(vn);
        rb = s6_cnt;
        start_pulse(8'h02);
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge PCLK);
            if (s6_cnt != rb) seen = 1'b1;
        end
        check("h4_reached_s6", {31'd0, seen}, 32'd1);
        #2 PRESETN = 1'b0;
        #1;
        check("h4_psel",     {31'd0, PSEL},       32'd0);
        check("h4_penable",  {31'd0, PENABLE},    32'd0);
        check("h4_pwrite",   {31'd0, PWRITE},     32'd0);
        check("h4_paddr",    {23'd0, PADDR},      32'd0);
        check("h4_pwdata",   {24'd0, PWDATA},     32'd0);
        check("h4_data_out", {16'd0, DATA_OUT},   32'd0);
        check("h4_dv",       {31'd0, DATA_VALID}, 32'd0);
        check("h4_busy",     {31'd0, BUSY},       32'd0);
        check("h4_err",      {31'd0, ERR},        32'd0);
        check("h4_err_code", {24'd0, ERR_CODE},   32'd0);
        check("h4_state",    {29'd0, DBG_STATE},  32'd0);
        rb = wr_log.size();
        repeat (3) @(negedge PCLK);
        PRESETN = 1'b1;
        repeat (3) @(negedge PCLK);
        check("h4_no_stop_on_reset", wr_log.size() - rb, 0);
        prep(vn);
        start_pulse(8'h02);
        finish(vn, 1'b0, "h4");

        check("dv_aligned_with_busy_fall", dv_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
